// File: rtl/iob_uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and byte width.
package iob_uart_tx_arb_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WRITE = 2'd2,
        HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/iob_reg.sv
// Generic register with asynchronous active-high reset to a parameterised value.
module iob_reg #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_o <= RST_VAL;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin picker: the search starts just after ptr and wraps modulo N.
module iob_rr_arbiter #(
    parameter int N = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % N);
    endfunction

    logic [N-1:0] rot;
    logic         found;

    // rot[0] is the requester right after ptr; the first set bit wins and is mapped back
    always_comb begin
        rot     = '0;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            rot[i] = req[wrap(int'(ptr) + 1 + i)];
        end
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found   = 1'b1;
                gnt_idx = wrap(int'(ptr) + 1 + i);
            end
        end
        gnt[gnt_idx] = found;
    end

endmodule

// File: rtl/iob_uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_core transmit path between N_REQ
// byte-stream producers; sequences the core's registered data / write-pulse handshake.
module iob_uart_tx_arbiter
    import iob_uart_tx_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    input  logic [DATA_W*N_REQ-1:0]  req_data_i,
    input  logic [N_REQ-1:0]         req_last_i,
    output logic [N_REQ-1:0]         req_ready_o,
    output logic [N_REQ-1:0]         grant_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic                     tx_en_o,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     tx_write_o,
    input  logic                     tx_ready_i
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0]     PTR_RST    = IDX_W'(N_REQ - 1);
    localparam logic [TIMEOUT_W-1:0] STALL_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    arb_state_t           state_q, state_d;
    logic [1:0]           state_bits_q;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]     gidx_q, gidx_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 last_q, last_d;
    logic                 write_q, write_d;
    logic                 timeout_q, timeout_d;
    logic                 txen_q;

    logic [N_REQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 cur_valid;
    logic                 cur_last;
    logic [DATA_W-1:0]    cur_data;
    logic                 release_now;

    iob_rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req_valid_i),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    iob_reg #(.W(2), .RST_VAL(IDLE)) u_state_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(state_d), .q_o(state_bits_q));
    iob_reg #(.W(N_REQ)) u_grant_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(grant_d), .q_o(grant_q));
    iob_reg #(.W(IDX_W)) u_gidx_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(gidx_d), .q_o(gidx_q));
    iob_reg #(.W(IDX_W), .RST_VAL(PTR_RST)) u_ptr_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(ptr_d), .q_o(ptr_q));
    iob_reg #(.W(TIMEOUT_W)) u_cnt_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(cnt_d), .q_o(cnt_q));
    iob_reg #(.W(DATA_W)) u_data_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(data_d), .q_o(data_q));
    iob_reg #(.W(1)) u_last_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(last_d), .q_o(last_q));
    iob_reg #(.W(1)) u_write_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(write_d), .q_o(write_q));
    iob_reg #(.W(1)) u_timeout_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(timeout_d), .q_o(timeout_q));
    iob_reg #(.W(1)) u_txen_reg (
        .clk_i(clk_i), .rst_i(rst_i), .d_i(en_i), .q_o(txen_q));

    assign state_q    = arb_state_t'(state_bits_q);
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != IDLE);
    assign timeout_o  = timeout_q;
    assign tx_en_o    = txen_q;
    assign tx_data_o  = data_q;
    assign tx_write_o = write_q;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gidx_q == IDX_W'(k)) begin
                cur_valid = req_valid_i[k];
                cur_last  = req_last_i[k];
                cur_data  = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Releasing the owner always parks ptr on it, so the next search starts after it
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        last_d      = last_q;
        write_d     = 1'b0;
        timeout_d   = 1'b0;
        req_ready_o = '0;
        release_now = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i && (|req_valid_i)) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!en_i) begin
                    release_now = 1'b1;
                end else if (cur_valid && tx_ready_i) begin
                    req_ready_o[gidx_q] = 1'b1;
                    data_d  = cur_data;
                    last_d  = cur_last;
                    write_d = 1'b1;
                    state_d = WRITE;
                end else if (!cur_valid) begin
                    // Counter would hit all-ones on this cycle: the owner has stalled too long
                    if (cnt_q == STALL_LAST) begin
                        timeout_d   = 1'b1;
                        release_now = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (last_q) begin
                    release_now = 1'b1;
                end else begin
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (release_now) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = IDLE;
        end
    end

endmodule

// File: tb/tb_iob_uart_tx_arbiter.sv
// Directed bench for iob_uart_tx_arbiter: a cycle table plus multi-cycle scenario sequences.
module tb_iob_uart_tx_arbiter;

    logic        clk;
    logic        rst_i;
    logic        en_i;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;
    logic        tx_en_o;
    logic [7:0]  tx_data_o;
    logic        tx_write_o;
    logic        tx_ready_i;

    iob_uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_W(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .tx_en_o     (tx_en_o),
        .tx_data_o   (tx_data_o),
        .tx_write_o  (tx_write_o),
        .tx_ready_i  (tx_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] last;
        logic       rdy;
        logic [3:0] grant;
        logic       busy;
        logic [3:0] rr;
        logic       wr;
        logic [7:0] data;
        logic       txen;
    } vec_t;

    vec_t vq[$];

    int total = 0;
    int bad   = 0;

    // Byte-source model: each requester presents src_data[k][src_pos[k]] until accepted
    logic [7:0] src_data [4][8];
    logic       src_last [4][8];
    int         src_len  [4];
    int         src_pos  [4];
    logic [3:0] src_en;
    logic       en_drive;
    logic       hold_nr;
    int         gap;

    logic [3:0] s_grant, s_ready;
    logic       s_busy, s_write, s_timeout;
    logic [7:0] s_data;
    int         n_timeout, n_ready, n_stray;
    logic [7:0] cap_data[$];
    logic [3:0] cap_grant[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic en, input logic [3:0] valid, input logic [3:0] last, input logic rdy,
                          input logic [3:0] grant, input logic busy, input logic [3:0] rr, input logic wr,
                          input logic [7:0] data, input logic txen);
        vec_t v;
        v.en = en; v.valid = valid; v.last = last; v.rdy = rdy;
        v.grant = grant; v.busy = busy; v.rr = rr; v.wr = wr; v.data = data; v.txen = txen;
        vq.push_back(v);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] valid, input logic [3:0] last, input logic rdy);
        en_i        = en;
        req_valid_i = valid;
        req_last_i  = last;
        tx_ready_i  = rdy;
        req_data_i  = 32'hA3A2_A1A0;
    endtask

    task automatic clearSources();
        for (int k = 0; k < 4; k++) begin
            src_len[k] = 0;
            src_pos[k] = 0;
        end
        src_en    = 4'b0000;
        en_drive  = 1'b1;
        hold_nr   = 1'b0;
        gap       = 0;
        n_timeout = 0;
        n_ready   = 0;
        cap_data.delete();
        cap_grant.delete();
    endtask

    task automatic addByte(input int k, input logic [7:0] d, input logic l);
        src_data[k][src_len[k]] = d;
        src_last[k][src_len[k]] = l;
        src_len[k]++;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic driveInputs();
        logic v;
        en_i = en_drive;
        for (int k = 0; k < 4; k++) begin
            v = src_en[k] && (src_pos[k] < src_len[k]);
            req_valid_i[k]        = v;
            req_data_i[k*8 +: 8]  = v ? src_data[k][src_pos[k]] : 8'h00;
            req_last_i[k]         = v ? src_last[k][src_pos[k]] : 1'b0;
        end
        tx_ready_i = !hold_nr && (gap == 0);
        if (gap > 0) gap--;
    endtask

    task automatic sampleOutputs();
        s_grant   = grant_o;
        s_busy    = busy_o;
        s_ready   = req_ready_o;
        s_write   = tx_write_o;
        s_data    = tx_data_o;
        s_timeout = timeout_o;
        if (s_write) begin
            cap_data.push_back(s_data);
            cap_grant.push_back(s_grant);
            gap = 4;
        end
        if (s_timeout) n_timeout++;
        if (s_ready != 4'b0000) n_ready++;
        if (((s_ready & ~s_grant) != 4'b0000) || ((s_ready != 4'b0000) && !s_busy)) n_stray++;
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            driveInputs();
            @(negedge clk);
            sampleOutputs();
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (s_ready[k]) src_pos[k]++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic found;
        int   wcyc, tcyc, next_grant;
        logic [3:0] grant_before, grant_at_to;

        n_stray = 0;
        clearSources();
        rst_i = 1'b1;
        applyStimulus(1'b1, 4'b1111, 4'b1111, 1'b1);
        #2;
        checkOutput("reset_grant",   grant_o,     0);
        checkOutput("reset_busy",    busy_o,      0);
        checkOutput("reset_ready",   req_ready_o, 0);
        checkOutput("reset_write",   tx_write_o,  0);
        checkOutput("reset_data",    tx_data_o,   0);
        checkOutput("reset_timeout", timeout_o,   0);
        checkOutput("reset_txen",    tx_en_o,     0);

        // Cycle table: en, valid, last, tx_ready | grant, busy, req_ready, write, tx_data, tx_en
        addVec(1, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'h00, 0);
        addVec(1, 4'hF, 4'hF, 1,  4'h1, 1, 4'h1, 0, 8'h00, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h1, 1, 4'h0, 1, 8'hA0, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h1, 1, 4'h0, 0, 8'hA0, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA0, 1);
        addVec(1, 4'hF, 4'hF, 0,  4'h2, 1, 4'h0, 0, 8'hA0, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h2, 1, 4'h2, 0, 8'hA0, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h2, 1, 4'h0, 1, 8'hA1, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h2, 1, 4'h0, 0, 8'hA1, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA1, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h4, 1, 4'h4, 0, 8'hA1, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h4, 1, 4'h0, 1, 8'hA2, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h4, 1, 4'h0, 0, 8'hA2, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA2, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h8, 1, 4'h8, 0, 8'hA2, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h8, 1, 4'h0, 1, 8'hA3, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h8, 1, 4'h0, 0, 8'hA3, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA3, 1);
        addVec(1, 4'hF, 4'hF, 1,  4'h1, 1, 4'h1, 0, 8'hA3, 1);
        addVec(0, 4'hF, 4'hF, 1,  4'h1, 1, 4'h0, 1, 8'hA0, 1);
        addVec(0, 4'hF, 4'hF, 1,  4'h1, 1, 4'h0, 0, 8'hA0, 0);
        addVec(0, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA0, 0);
        addVec(0, 4'hF, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA0, 0);
        addVec(1, 4'h4, 4'hF, 1,  4'h0, 0, 4'h0, 0, 8'hA0, 0);
        addVec(1, 4'h4, 4'hF, 1,  4'h4, 1, 4'h4, 0, 8'hA0, 1);
        addVec(1, 4'h4, 4'hF, 1,  4'h4, 1, 4'h0, 1, 8'hA2, 1);

        @(posedge clk);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            applyStimulus(vq[i].en, vq[i].valid, vq[i].last, vq[i].rdy);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_grant", i), grant_o,     vq[i].grant);
            checkOutput($sformatf("vec%0d_busy", i),  busy_o,      vq[i].busy);
            checkOutput($sformatf("vec%0d_ready", i), req_ready_o, vq[i].rr);
            checkOutput($sformatf("vec%0d_write", i), tx_write_o,  vq[i].wr);
            checkOutput($sformatf("vec%0d_data", i),  tx_data_o,   vq[i].data);
            checkOutput($sformatf("vec%0d_txen", i),  tx_en_o,     vq[i].txen);
            checkOutput($sformatf("vec%0d_to", i),    timeout_o,   0);
            @(posedge clk);
            #1;
        end

        // Round robin with a UART that drops tx_ready for 4 cycles after each write
        doReset();
        clearSources();
        for (int k = 0; k < 4; k++) addByte(k, 8'hA0 + 8'(k), 1'b1);
        src_en = 4'b1111;
        runCycles(50);
        checkOutput("rr_count", cap_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_data.size()) begin
                checkOutput($sformatf("rr_data%0d", i),  cap_data[i],  8'hA0 + i);
                checkOutput($sformatf("rr_grant%0d", i), cap_grant[i], 1 << i);
            end
        end

        // Packet lock: req1 keeps the UART for its whole 3-byte packet while req0 waits
        doReset();
        clearSources();
        addByte(1, 8'h11, 1'b0);
        addByte(1, 8'h22, 1'b0);
        addByte(1, 8'h33, 1'b1);
        addByte(0, 8'h55, 1'b1);
        src_en = 4'b0010;
        runCycles(1);
        src_en = 4'b0011;
        runCycles(40);
        checkOutput("lock_count", cap_data.size(), 4);
        if (cap_data.size() == 4) begin
            checkOutput("lock_data0",  cap_data[0],  8'h11);
            checkOutput("lock_data1",  cap_data[1],  8'h22);
            checkOutput("lock_data2",  cap_data[2],  8'h33);
            checkOutput("lock_data3",  cap_data[3],  8'h55);
            checkOutput("lock_grant0", cap_grant[0], 4'b0010);
            checkOutput("lock_grant1", cap_grant[1], 4'b0010);
            checkOutput("lock_grant2", cap_grant[2], 4'b0010);
            checkOutput("lock_grant3", cap_grant[3], 4'b0001);
        end

        // Backpressure: a long tx_ready low is not a stall
        doReset();
        clearSources();
        addByte(2, 8'h77, 1'b1);
        src_en  = 4'b0100;
        hold_nr = 1'b1;
        runCycles(500);
        checkOutput("bp_no_ready",   n_ready,         0);
        checkOutput("bp_no_write",   cap_data.size(), 0);
        checkOutput("bp_no_timeout", n_timeout,       0);
        checkOutput("bp_grant",      s_grant,         4'b0100);
        checkOutput("bp_busy",       s_busy,          1);
        hold_nr = 1'b0;
        runCycles(1);
        checkOutput("bp_ready_rise", s_ready, 4'b0100);
        checkOutput("bp_write_not_yet", s_write, 0);
        runCycles(1);
        checkOutput("bp_write", s_write, 1);
        checkOutput("bp_data",  s_data,  8'h77);

        // Stall timeout: req3 goes silent mid-packet, req0 takes over afterwards
        doReset();
        clearSources();
        addByte(3, 8'h3A, 1'b0);
        addByte(0, 8'h0C, 1'b1);
        src_en       = 4'b1000;
        wcyc         = -1;
        tcyc         = -1;
        next_grant   = -1;
        grant_before = 4'b0000;
        grant_at_to  = 4'hF;
        for (int c = 0; c < 40; c++) begin
            grant_before = s_grant;
            runCycles(1);
            if (c == 0) src_en = 4'b1001;
            if (s_write && wcyc < 0) wcyc = c;
            if (s_timeout && tcyc < 0) begin
                tcyc        = c;
                grant_at_to = s_grant;
                checkOutput("to_grant_before", grant_before, 4'b1000);
            end
            if (tcyc >= 0 && c > tcyc && next_grant < 0 && s_grant != 4'b0000) next_grant = int'(s_grant);
        end
        checkOutput("to_pulse_count", n_timeout,   1);
        checkOutput("to_latency",     tcyc - wcyc, 17);
        checkOutput("to_grant_clear", grant_at_to, 4'b0000);
        checkOutput("to_next_grant",  next_grant,  1);
        checkOutput("to_writes",      cap_data.size(), 2);
        if (cap_data.size() == 2) checkOutput("to_req0_data", cap_data[1], 8'h0C);

        // Enable drop while waiting in SEND
        doReset();
        clearSources();
        addByte(1, 8'h21, 1'b0);
        addByte(1, 8'h22, 1'b1);
        src_en  = 4'b0010;
        hold_nr = 1'b1;
        runCycles(3);
        checkOutput("en_grant_held", s_grant, 4'b0010);
        en_drive = 1'b0;
        runCycles(1);
        checkOutput("en_no_ready", s_ready, 0);
        runCycles(1);
        checkOutput("en_grant_drop", s_grant, 0);
        checkOutput("en_busy_drop",  s_busy,  0);
        hold_nr = 1'b0;
        runCycles(5);
        checkOutput("en_idle_grant", s_grant, 0);
        checkOutput("en_no_write",   cap_data.size(), 0);
        en_drive = 1'b1;
        runCycles(15);
        checkOutput("en_rearb_count", cap_data.size(), 2);
        if (cap_data.size() == 2) begin
            checkOutput("en_rearb_data0", cap_data[0], 8'h21);
            checkOutput("en_rearb_data1", cap_data[1], 8'h22);
        end

        // Asynchronous reset in the middle of a write pulse
        doReset();
        clearSources();
        addByte(2, 8'h99, 1'b1);
        src_en = 4'b0100;
        found  = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            driveInputs();
            @(negedge clk);
            if (tx_write_o === 1'b1) begin
                found = 1'b1;
            end else begin
                sampleOutputs();
                @(posedge clk);
                #1;
                for (int k = 0; k < 4; k++) if (s_ready[k]) src_pos[k]++;
            end
        end
        checkOutput("rst_write_seen", found, 1);
        rst_i = 1'b1;
        #1;
        checkOutput("rst_async_write", tx_write_o,  0);
        checkOutput("rst_async_data",  tx_data_o,   0);
        checkOutput("rst_async_grant", grant_o,     0);
        checkOutput("rst_async_busy",  busy_o,      0);
        checkOutput("rst_async_ready", req_ready_o, 0);
        checkOutput("rst_async_txen",  tx_en_o,     0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;

        checkOutput("ready_only_on_grant", n_stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iob_uart_tx_arbiter.md
Name: iob_uart_tx_arbiter

Overview:
- Shares one uart_core transmit path between N_REQ byte-stream requesters.
- Grants are round-robin and packet-locked: a requester keeps the UART until its byte flagged last is sent.
- Sequences the core's write handshake: presents registered tx data with a one-cycle write pulse, then respects tx_ready.
- Sits between on-chip producers (CPU mailbox, debug/log engines) and uart_core, inside the iob_uart wrapper.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_W, 8, width of the stall counter; the stall limit is 2^TIMEOUT_W-1 cycles.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  asynchronous active-high reset
- en_i  input  1  transmit enable, from the UART_TXEN register
- req_valid_i  input  N_REQ  per-requester byte valid
- req_data_i  input  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k]
- req_last_i  input  N_REQ  byte is the last of its packet
- req_ready_o  output  N_REQ  byte accepted this cycle
- grant_o  output  N_REQ  one-hot current owner; zero when idle
- busy_o  output  1  a packet is in progress (state != IDLE)
- timeout_o  output  1  one-cycle pulse when a stalled owner is released
- tx_en_o  output  1  to uart_core tx_en
- tx_data_o  output  8  to uart_core tx_data, registered
- tx_write_o  output  1  to uart_core data_write_en, one-cycle pulse
- tx_ready_i  input  1  from uart_core tx_ready

Behaviour:
- Clock and reset: single clock clk_i. rst_i is asynchronous and active-high; every flop clears immediately on assertion.
- Reset values: state IDLE; grant_o, req_ready_o, tx_data_o, tx_write_o, timeout_o, busy_o and tx_en_o all 0; round-robin pointer ptr = N_REQ-1, so requester 0 has first priority.
- tx_en_o is en_i registered, with 1 cycle of latency.
- States: IDLE, SEND, WRITE, HOLD.
- IDLE:
  - If en_i=1 and |req_valid_i, pick the first valid index scanning ptr+1, ptr+2, ... modulo N_REQ.
  - Register the one-hot grant, clear the stall counter, go to SEND.
  - No byte is accepted in this cycle.
- SEND:
  - Handshake: if req_valid_i[g] & tx_ready_i & en_i, assert req_ready_o[g]=1 combinationally in the same cycle. Capture tx_data_o <= data[g] and last_q <= last[g]. Set tx_write_o <= 1 and go to WRITE.
  - Stall: if req_valid_i[g]=0, increment the stall counter. When it reaches all-ones, pulse timeout_o, set ptr <= g, clear grant and go to IDLE.
  - The stall counter does not count while valid=1 and tx_ready_i=0; a UART backpressure wait is not a stall.
  - If en_i=0: clear grant, set ptr <= g, go to IDLE. No timeout pulse. The rest of the packet is dropped from arbitration; the requester re-arbitrates later.
- WRITE:
  - tx_write_o=1 for exactly this cycle, with tx_data_o stable.
  - Go to HOLD.
- HOLD:
  - One guard cycle that ignores tx_ready_i, covering the core's 1-cycle tx_ready deassertion latency.
  - If last_q: set ptr <= g, clear grant, go to IDLE.
  - Else: go to SEND and clear the stall counter.
- Throughput: at most one byte per 3 cycles at the controller; in practice the UART bit time dominates.
- req_ready_o is never asserted outside SEND, and only on the granted index.
- en_i falling during WRITE or HOLD: the in-flight byte completes. Release happens at the next SEND.
- Reset mid-packet: immediate return to IDLE. Any byte already written is owned by uart_core; the remainder is lost.
- Simultaneous valid from all requesters with ptr=N_REQ-1: grants go 0, 1, 2, 3, 0, ...
- With a single persistent requester, it is re-granted after each packet with a 1-cycle IDLE gap.

Decomposition:
- Package iob_uart_tx_arb_pkg holds:
  - state encodings: IDLE=2'd0, SEND=2'd1, WRITE=2'd2, HOLD=2'd3;
  - the DATA byte width constant (8).
- Sub-module iob_rr_arbiter (parameter N):
  - inputs: req[N], ptr index;
  - outputs: one-hot gnt[N] and gnt_idx;
  - purely combinational rotate / priority / rotate-back.
- All flops use iob_reg instances with the codebase's asynchronous reset.

Test Plan:
- Round-robin order:
  - Stimulus: after reset, en_i=1; all 4 requesters send 1-byte packets 0xA0..0xA3 (last=1); model tx_ready is 1 except for 4 cycles after each write.
  - Required: tx_write_o pulses carry 0xA0, 0xA1, 0xA2, 0xA3 in that order; grant_o goes 0001, 0010, 0100, 1000.
- Packet lock:
  - Stimulus: req1 sends a 3-byte packet 0x11, 0x22, 0x33 with last on 0x33; req0 stays valid throughout.
  - Required: tx_data_o sequence is 0x11, 0x22, 0x33 before any req0 byte; grant_o holds 0010 across all 3 bytes.
- Backpressure:
  - Stimulus: hold tx_ready_i=0 for 500 cycles while req2 is valid.
  - Required: no req_ready_o, no tx_write_o and no timeout_o. The byte is written 1 cycle after tx_ready_i rises (ready pulse), with the write on the following cycle.
- Stall timeout:
  - Stimulus: TIMEOUT_W=4; req3 sends a first byte (last=0), then drops valid.
  - Required: timeout_o pulses exactly once, 15 cycles after SEND re-entry; grant_o returns to 0; req0 is granted next.
- Enable drop and reset:
  - Stimulus: en_i=0 mid-packet while in SEND.
  - Required: grant_o is 0 on the next cycle and busy_o=0; no write occurs.
  - Stimulus: assert rst_i asynchronously during WRITE.
  - Required: tx_write_o and all outputs go to 0 immediately, without waiting for a clock edge.
